// File: rtl/word_packer.sv
// word_packer: gathers W-bit lanes from a valid/ready stream into W*N-bit
// words. A flush emits the partial word with its unfilled lanes set to zero.
// The word goes into a single output register that can accept a new word on
// the same edge the consumer takes the current one.
module word_packer #(
    parameter int W         = 4,
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   flush,
    output logic [W*N-1:0]         out_data,
    output logic [$clog2(N):0]     out_count,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CNT_W = $clog2(N);
    localparam int OUT_W = CNT_W + 1;

    logic [W*N-1:0]   acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [W*N-1:0]   merged;
    logic [OUT_W-1:0] k;
    logic             emit;

    // Lanes only move when the output register is free or is draining this cycle.
    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Merge the incoming lane into the accumulator and decide whether a word leaves this edge.
    always_comb begin
        // NOTE: default every combinational output first so that no path leaves it unassigned, which would infer a latch.
        merged = acc;
        for (int i = 0; i < N; i++) begin
            if (accept && cnt == CNT_W'(i)) begin
                if (MSB_FIRST)
                    merged[(N-1-i)*W +: W] = in_data;
                else
                    merged[i*W +: W] = in_data;
            end
        end
        k    = {1'b0, cnt} + OUT_W'(accept);
        // A full word can only appear on an accepted lane, and accept already implies in_ready.
        emit = in_ready & ((k == OUT_W'(N)) | (flush & (k != '0)));
    end

    // Accumulator, lane counter and output register.
    always_ff @(posedge clk) begin
        // NOTE: all state is registered with non-blocking assignments so every reader sees the pre-edge value.
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (emit) begin
            out_data  <= merged;
            out_count <= k;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            if (accept) begin
                acc <= merged;
                cnt <= cnt + CNT_W'(1);
            end
            if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_packer.sv
// Bench for word_packer: two instances (MSB-first and LSB-first) share one
// stimulus stream. A queue-based model predicts every output on every cycle,
// and literal values from hand-worked examples pin that model.
module tb_word_packer;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int DW = W * N;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready_m, in_ready_l;
    logic [DW-1:0] out_data_m, out_data_l;
    logic [CW-1:0] out_count_m, out_count_l;
    logic          out_valid_m, out_valid_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    word_packer #(.W(W), .N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .flush(flush), .out_data(out_data_m),
        .out_count(out_count_m), .out_valid(out_valid_m), .out_ready(out_ready)
    );

    word_packer #(.W(W), .N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .flush(flush), .out_data(out_data_l),
        .out_count(out_count_l), .out_valid(out_valid_l), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a list of accepted lanes and the word currently offered.
    int            lanes[$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_msb = '0;
    logic [DW-1:0] m_lsb = '0;
    int            m_count = 0;

    always @(posedge clk) begin
        bit rdy;
        if (rst) begin
            lanes.delete();
            m_valid = 1'b0;
            m_msb   = '0;
            m_lsb   = '0;
            m_count = 0;
        end else begin
            rdy = !m_valid || out_ready;
            if (in_valid && rdy) lanes.push_back(int'(in_data));
            if (rdy && (lanes.size() == N || (flush && lanes.size() != 0))) begin
                m_msb = '0;
                m_lsb = '0;
                foreach (lanes[j]) begin
                    m_msb = m_msb | (DW'(lanes[j]) << (W * (N - 1 - j)));
                    m_lsb = m_lsb | (DW'(lanes[j]) << (W * j));
                end
                m_count = lanes.size();
                m_valid = 1'b1;
                lanes.delete();
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare both instances against the model every cycle on the falling edge.
    always @(negedge clk) begin
        check("in_ready_msb", 32'(in_ready_m), 32'(!m_valid || out_ready));
        check("in_ready_lsb", 32'(in_ready_l), 32'(!m_valid || out_ready));
        check("out_valid_msb", 32'(out_valid_m), 32'(m_valid));
        check("out_valid_lsb", 32'(out_valid_l), 32'(m_valid));
        if (m_valid) begin
            check("out_data_msb", 32'(out_data_m), 32'(m_msb));
            check("out_data_lsb", 32'(out_data_l), 32'(m_lsb));
            check("out_count_msb", 32'(out_count_m), 32'(m_count));
            check("out_count_lsb", 32'(out_count_l), 32'(m_count));
        end
    end

    // Drive one cycle of inputs, then return 2 time units after the edge that sampled them.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_word(input string name, input logic [DW-1:0] msb,
                               input logic [DW-1:0] lsb, input int count);
        check({name, "_valid"}, 32'(out_valid_m), 32'd1);
        check({name, "_msb"}, 32'(out_data_m), 32'(msb));
        check({name, "_lsb"}, 32'(out_data_l), 32'(lsb));
        check({name, "_count"}, 32'(out_count_m), 32'(count));
    endtask

    initial begin
        // Reset
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("reset_valid", 32'(out_valid_m), 32'd0);
        check("reset_data", 32'(out_data_m), 32'd0);
        check("reset_count", 32'(out_count_m), 32'd0);
        rst = 1'b0;

        // Four lanes in a row, consumer always ready
        cyc(1, 4'hA, 0, 1);
        cyc(1, 4'hB, 0, 1);
        cyc(1, 4'hC, 0, 1);
        cyc(1, 4'hD, 0, 1);
        expect_word("full_abcd", 16'hABCD, 16'hDCBA, 4);

        // Backpressure: the word is held and lane 5 stalls
        in_valid = 1'b1; in_data = 4'h5; flush = 1'b0; out_ready = 1'b0;
        #1;
        check("stall_in_ready", 32'(in_ready_m), 32'd0);
        @(posedge clk);
        #2;
        expect_word("held_abcd", 16'hABCD, 16'hDCBA, 4);
        cyc(1, 4'h5, 0, 1);
        check("drained_valid", 32'(out_valid_m), 32'd0);
        cyc(1, 4'h6, 0, 1);
        cyc(1, 4'h7, 0, 1);
        cyc(1, 4'h8, 0, 1);
        expect_word("full_5678", 16'h5678, 16'h8765, 4);

        // Flush of a two-lane partial word
        cyc(1, 4'h1, 0, 1);
        cyc(1, 4'hE, 0, 1);
        cyc(0, 4'h0, 1, 1);
        expect_word("flush_1e", 16'h1E00, 16'h00E1, 2);
        cyc(1, 4'h2, 0, 1);
        cyc(1, 4'h3, 0, 1);
        cyc(1, 4'h4, 0, 1);
        cyc(1, 4'h5, 0, 1);
        expect_word("full_2345", 16'h2345, 16'h5432, 4);

        // Flush together with a lane, then flush with nothing held
        cyc(1, 4'h7, 0, 1);
        cyc(1, 4'h8, 0, 1);
        cyc(1, 4'h9, 1, 1);
        expect_word("flush_789", 16'h7890, 16'h0987, 3);
        cyc(0, 4'h0, 1, 1);
        check("empty_flush_valid", 32'(out_valid_m), 32'd0);

        // Flush after two lanes
        cyc(1, 4'h1, 0, 1);
        cyc(1, 4'h2, 0, 1);
        cyc(0, 4'h0, 1, 1);
        expect_word("flush_12", 16'h1200, 16'h0021, 2);

        // Reset mid-word drops the held lanes
        cyc(1, 4'h1, 0, 1);
        cyc(1, 4'h2, 0, 1);
        rst = 1'b1;
        cyc(0, 4'h0, 0, 1);
        rst = 1'b0;
        check("midreset_valid", 32'(out_valid_m), 32'd0);
        check("midreset_data", 32'(out_data_m), 32'd0);
        cyc(1, 4'h3, 0, 1);
        cyc(1, 4'h4, 0, 1);
        cyc(1, 4'h5, 0, 1);
        cyc(1, 4'h6, 0, 1);
        expect_word("full_3456", 16'h3456, 16'h6543, 4);

        // Flush requested while the output is stalled is ignored until it drains
        cyc(1, 4'hA, 0, 1);
        cyc(1, 4'hB, 0, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(1, 4'hC, 1, 0);
        expect_word("stalled_ab", 16'hAB00, 16'h00BA, 2);
        cyc(1, 4'hC, 1, 1);
        expect_word("flush_c", 16'hC000, 16'h000C, 1);
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 1);
        check("idle_valid", 32'(out_valid_m), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
Parametrised, clocked successor to the lane-concatenation blocks. It accepts a stream of W-bit lanes over a valid/ready handshake and concatenates every N accepted lanes into one W*N-bit word. Lane order is selectable. A flush input emits a zero-padded partial word. It sits between narrow producers (nibble sources, serial decoders) and wide consumers in the logic-lab designs.

Parameters:
W, 4, lane width in bits (>=1)
N, 4, lanes per output word (>=2)
MSB_FIRST, 1, 1 = first accepted lane lands in the top lane (the {q,w,e,r} ordering); 0 = first lane lands in bits [W-1:0]

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_data  input  W  lane to pack
in_valid  input  1  in_data is valid
in_ready  output  1  packer can accept a lane this cycle
flush  input  1  request emission of the current partial word
out_data  output  W*N  packed word
out_count  output  $clog2(N)+1  number of valid lanes in out_data (1..N)
out_valid  output  1  out_data/out_count are valid
out_ready  input  1  consumer takes the word this cycle

Behaviour:
- The interface is one clock and a synchronous, active-high reset. Ports are named clk and rst.
- State:
  - acc (W*N bits): accumulator.
  - cnt (0..N-1): lanes held in acc.
  - Output register: out_data, out_count, out_valid.
  - Conceptual states: EMPTY (cnt=0), PARTIAL (cnt>0), crossed with OUT_FULL (out_valid=1) or OUT_FREE.
- Reset (rst=1 at an edge) sets acc=0, cnt=0, out_valid=0, out_data=0 and out_count=0. Reset takes priority over all inputs. Reset mid-word discards the partial lanes, and no word is emitted.
- in_ready = !out_valid | out_ready. This is combinational. Lanes stall whenever the output register is occupied and not draining, even if the next lane would not complete a word.
- A lane is accepted when in_valid & in_ready at the edge.
  - MSB_FIRST=1: the lane is written to acc[W*N-1-cnt*W -: W].
  - MSB_FIRST=0: the lane is written to acc[cnt*W +: W].
  - cnt increments by 1.
- Full word: when the accepted lane makes cnt+1==N, the complete word (acc with the new lane merged) goes to out_data on the same edge. out_count=N, out_valid=1, cnt=0, acc=0.
  - Latency: out_valid rises in the cycle after the Nth lane handshake.
- Flush is evaluated only when in_ready=1. A flush with in_ready=0 is ignored, and the requester holds it.
  - Let k = cnt + (lane accepted this cycle ? 1 : 0). A lane accepted in the same cycle is included before flushing.
  - k==0: no effect.
  - 0<k<N: emit acc with the new lane merged. Unfilled lanes are zero. out_count=k, out_valid=1, cnt=0, acc=0.
  - k==N: normal full word.
- Output handshake: the word transfers on out_valid & out_ready. out_valid clears unless a new word is loaded on the same edge; back-to-back words are allowed.
  - out_data and out_count hold stable while out_valid & !out_ready.
- cnt never reaches N. There is no wrap beyond N-1. No data is lost or duplicated under any pattern of stalls.

Test Plan:
1. W=4, N=4, MSB_FIRST=1, out_ready=1. Lanes A,B,C,D on consecutive cycles -> one cycle after D: out_valid=1, out_data=16'hABCD, out_count=4. in_ready stays 1 throughout.
2. Backpressure: after case 1, hold out_ready=0 and present lane 5 -> in_ready=0, out_data held at 16'hABCD. Raise out_ready -> word taken, 5 accepted the same cycle. Lanes 6,7,8 -> 16'h5678.
3. Flush: lanes 1,E, then flush=1 with in_valid=0 -> out_data=16'h1E00, out_count=2. Next lanes 2,3,4,5 -> 16'h2345, out_count=4.
4. Simultaneous flush and lane: lanes 7,8, then lane 9 with flush=1 -> out_data=16'h7890, out_count=3. Flush with cnt=0 and in_valid=0 -> no output.
5. MSB_FIRST=0: lanes A,B,C,D -> out_data=16'hDCBA. Flush after lanes 1,2 -> 16'h0021, out_count=2.
6. Reset mid-word: lanes 1,2, then rst=1 for one cycle -> out_valid=0, out_data=0. Lanes 3,4,5,6 -> 16'h3456. No residual 1,2 appears.
